// File: rtl/rf_addr_arb_pkg.sv
// Shared definitions for the register-address arbiter: state encodings,
// default hold limit and the round-robin pick used from IDLE and on release.
package rf_addr_arb_pkg;

  localparam int unsigned ST_W         = 2;
  localparam int unsigned HOLD_W       = 4;
  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned MAX_HOLD_DEF = 8;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_GRANT_A = 2'd1;
  localparam logic [ST_W-1:0] ST_GRANT_B = 2'd2;

  // Single requester wins outright; on contention the one not served last wins.
  function automatic logic [ST_W-1:0] arb_pick(input logic req_a,
                                               input logic req_b,
                                               input logic last_b);
    logic [ST_W-1:0] st;
    st = ST_IDLE;
    if (req_a && (!req_b || last_b)) begin
      st = ST_GRANT_A;
    end else if (req_b) begin
      st = ST_GRANT_B;
    end
    return st;
  endfunction

endpackage

// File: rtl/rf_addr_arb_mux4.sv
// 4-bit 2:1 address mux; sel=0 selects in_a, sel=1 selects in_b.
module mux4
  import rf_addr_arb_pkg::*;
(
  input  logic [ADDR_W-1:0] in_a,
  input  logic [ADDR_W-1:0] in_b,
  input  logic              sel,
  output logic [ADDR_W-1:0] y
);

  assign y = sel ? in_b : in_a;

endmodule

// File: rtl/rf_addr_arb.sv
// Two-requester arbiter for the shared register-address path, with
// round-robin fairness and a hold limit that forcibly revokes long grants.
module rf_addr_arb
  import rf_addr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              done_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              done_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [ST_W-1:0]   st_q, st_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              last_b_q, last_b_d;
  logic              sel_q, sel_d;
  logic              gnt_a_q, gnt_b_q, valid_q, timeout_q, timeout_d;
  logic              own_req, own_done, rel, expire;

  // Next state: arbitrate from IDLE, or on release/expiry re-arbitrate in the same cycle.
  always_comb begin
    st_d      = st_q;
    cnt_d     = '0;
    last_b_d  = last_b_q;
    timeout_d = 1'b0;
    sel_d     = sel_q;
    own_req   = (st_q == ST_GRANT_B) ? req_b  : req_a;
    own_done  = (st_q == ST_GRANT_B) ? done_b : done_a;
    rel       = own_done || !own_req;
    expire    = (cnt_q == HOLD_LAST);

    if (st_q == ST_IDLE) begin
      st_d = arb_pick(req_a, req_b, last_b_q);
    end else if (rel || expire) begin
      last_b_d  = (st_q == ST_GRANT_B);
      timeout_d = !rel;
      st_d      = arb_pick(req_a, req_b, last_b_d);
    end else begin
      cnt_d = cnt_q + HOLD_W'(1);
    end

    if (st_d == ST_GRANT_A) begin
      sel_d = 1'b0;
    end else if (st_d == ST_GRANT_B) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      sel_q     <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      sel_q     <= sel_d;
      gnt_a_q   <= (st_d == ST_GRANT_A);
      gnt_b_q   <= (st_d == ST_GRANT_B);
      valid_q   <= (st_d == ST_GRANT_A) || (st_d == ST_GRANT_B);
      timeout_q <= timeout_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign sel        = sel_q;
  assign addr_valid = valid_q;
  assign timeout    = timeout_q;

  mux4 u_mux4 (
    .in_a (addr_a),
    .in_b (addr_b),
    .sel  (sel_q),
    .y    (addr_out)
  );

endmodule

// File: tb/tb_rf_addr_arb.sv
// Bench for rf_addr_arb: directed scenarios with literal expectations plus
// a long randomized run checked each cycle against an ownership model.
module tb_rf_addr_arb;

  localparam int unsigned MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, done_a = 1'b0, req_b = 1'b0, done_b = 1'b0;
  logic [3:0] addr_a = 4'h0, addr_b = 4'h0;
  logic       gnt_a, gnt_b, sel, addr_valid, timeout;
  logic [3:0] addr_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the path, how many cycles it has held it, who was served last.
  int m_own  = 0;   // 0 none, 1 A, 2 B
  int m_run  = 0;
  bit m_lastb = 1'b1;
  bit m_sel  = 1'b0;
  bit m_to   = 1'b0;

  rf_addr_arb #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .done_a(done_a),
    .req_b(req_b), .addr_b(addr_b), .done_b(done_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .addr_out(addr_out), .addr_valid(addr_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pick(input bit ra, input bit rb, input bit lb);
    if (ra && rb) return lb ? 1 : 2;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  task automatic model_step();
    bit released;
    if (rst) begin
      m_own = 0; m_run = 0; m_lastb = 1'b1; m_sel = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_own == 0) begin
        m_own = pick(req_a, req_b, m_lastb);
      end else begin
        released = (m_own == 1) ? (done_a || !req_a) : (done_b || !req_b);
        if (released || m_run == MAX_HOLD) begin
          m_to    = !released;
          m_lastb = (m_own == 2);
          m_own   = pick(req_a, req_b, m_lastb);
          m_run   = 0;
        end
      end
      if (m_own == 0) m_run = 0;
      else m_run++;
      if (m_own == 1) m_sel = 1'b0;
      else if (m_own == 2) m_sel = 1'b1;
    end
  endtask

  // Every cycle: advance the model on the edge, then compare shortly after.
  always @(posedge clk) begin
    model_step();
    #1;
    check("gnt_a", gnt_a, m_own == 1);
    check("gnt_b", gnt_b, m_own == 2);
    check("addr_valid", addr_valid, m_own != 0);
    check("sel", sel, m_sel);
    check("timeout", timeout, m_to);
    check("one_hot_gnt", gnt_a & gnt_b, 1'b0);
    if (m_own == 1) check("addr_out_a", addr_out, addr_a);
    if (m_own == 2) check("addr_out_b", addr_out, addr_b);
  end

  task automatic cyc(input bit r, input bit ra, input logic [3:0] aa, input bit da,
                     input bit rb, input logic [3:0] ab, input bit db);
    @(negedge clk);
    rst = r; req_a = ra; addr_a = aa; done_a = da;
    req_b = rb; addr_b = ab; done_b = db;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ra, rb;
    // Reset state
    cyc(1, 0, 4'h0, 0, 0, 4'h0, 0);
    cyc(1, 0, 4'h0, 0, 0, 4'h0, 0);
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_sel", sel, 0);

    // Single requester, one-cycle latency
    cyc(0, 1, 4'h3, 0, 0, 4'h0, 0);
    check("lat_gnt_a", gnt_a, 1);
    check("lat_gnt_b", gnt_b, 0);
    check("lat_sel", sel, 0);
    check("lat_addr", addr_out, 4'h3);

    // Contention, then done_a hands straight over to B
    cyc(0, 1, 4'h3, 0, 1, 4'h9, 0);
    check("hold_gnt_a", gnt_a, 1);
    cyc(0, 1, 4'h3, 1, 1, 4'h9, 0);
    check("handover_gnt_b", gnt_b, 1);
    check("handover_gnt_a", gnt_a, 0);
    check("handover_valid", addr_valid, 1);
    check("handover_sel", sel, 1);
    check("handover_addr", addr_out, 4'h9);

    // B holds for MAX_HOLD cycles, then is revoked in favour of A
    for (int i = 2; i <= MAX_HOLD; i++) begin
      cyc(0, 1, 4'h3, 0, 1, 4'h9, 0);
      check("b_held", gnt_b, 1);
      check("b_no_timeout", timeout, 0);
    end
    cyc(0, 1, 4'h3, 0, 1, 4'h9, 0);
    check("to_gnt_a", gnt_a, 1);
    check("to_gnt_b", gnt_b, 0);
    check("to_pulse", timeout, 1);
    check("to_addr", addr_out, 4'h3);

    // done_b while A owns the path changes nothing, including A's hold budget
    cyc(0, 1, 4'h3, 0, 1, 4'h9, 1);
    check("doneb_gnt_a", gnt_a, 1);
    check("doneb_timeout", timeout, 0);
    for (int i = 3; i <= MAX_HOLD; i++) begin
      cyc(0, 1, 4'h3, 0, 1, 4'h9, 0);
      check("a_held", gnt_a, 1);
    end
    cyc(0, 1, 4'h3, 0, 1, 4'h9, 0);
    check("a_to_gnt_b", gnt_b, 1);
    check("a_to_pulse", timeout, 1);

    // Reset in the middle of a B grant, then contention favours A
    cyc(1, 1, 4'h3, 0, 1, 4'h9, 0);
    check("midrst_gnt_a", gnt_a, 0);
    check("midrst_gnt_b", gnt_b, 0);
    check("midrst_valid", addr_valid, 0);
    check("midrst_sel", sel, 0);
    cyc(0, 1, 4'h3, 0, 1, 4'h9, 0);
    check("postrst_gnt_a", gnt_a, 1);

    // Lone requester is re-granted across its timeout without an idle cycle
    cyc(1, 0, 4'h0, 0, 0, 4'h0, 0);
    for (int i = 1; i <= MAX_HOLD; i++) begin
      cyc(0, 0, 4'h0, 0, 1, 4'h5, 0);
      check("lone_b", gnt_b, 1);
    end
    cyc(0, 0, 4'h0, 0, 1, 4'h5, 0);
    check("regrant_gnt_b", gnt_b, 1);
    check("regrant_valid", addr_valid, 1);
    check("regrant_timeout", timeout, 1);

    // Randomized traffic
    ra = 1'b0; rb = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 5) == 0) ra = ~ra;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      cyc($urandom_range(0, 299) == 0, ra, 4'($urandom), $urandom_range(0, 6) == 0,
          rb, 4'($urandom), $urandom_range(0, 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
